// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential restoring divider (seq_divider).
//   - div_state_t : controller state encoding. The FIXUP state is present here
//                   in every build but is only entered when SIGNED_DIV_EN is
//                   defined.
//   - div_cnt_w() : width of the quotient-bit counter for a given operand
//                   width. The counter must be able to hold WIDTH itself.
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_START  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_SUB    = 3'd4,
        ST_FIXUP  = 3'd5,
        ST_DONE   = 3'd6
    } div_state_t;

    // Counter width: $clog2(width)+1 bits so the count can reach 'width'.
    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   Combinational datapath slice of the restoring divider. Provides both the
//   one-bit left shift of the {R,Q} pair (used in SHIFT) and the trial
//   subtraction of the divisor from the partial remainder (used in SUB).
//
// Parameters
//   WIDTH  operand width in bits (>=2)
//
// Ports
//   r      in   WIDTH  current partial remainder
//   q      in   WIDTH  current quotient / remaining dividend bits
//   d      in   WIDTH  divisor (magnitude in the signed build)
//   r_sh   out  WIDTH  remainder half of {r,q} << 1
//   q_sh   out  WIDTH  quotient half of {r,q} << 1
//   r_new  out  WIDTH  remainder after the trial subtraction (restored if negative)
//   q_bit  out  1      quotient bit produced by the trial subtraction
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_sh,
    output logic [WIDTH-1:0] q_sh,
    output logic [WIDTH-1:0] r_new,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    always_comb begin
        // MSB of q moves into the LSB of r; q gets a zero that SUB overwrites.
        r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
        q_sh  = {q[WIDTH-2:0], 1'b0};

        // One extra bit so a borrow shows up as trial[WIDTH]==1.
        trial = {1'b0, r} - {1'b0, d};
        q_bit = ~trial[WIDTH];
        r_new = q_bit ? trial[WIDTH-1:0] : r;
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider, one quotient bit every two clocks
//   (SHIFT then SUB). The divisor is loaded from the switches S with
//   LoadDivisor; the dividend is taken from S when Run starts a division.
//
// Build option
//   SIGNED_DIV_EN  defined   : two's-complement operands. Magnitudes are
//                              divided, then a FIXUP cycle applies signs
//                              (quotient negated if signs differ, remainder
//                              takes the dividend's sign).
//                  undefined : unsigned only, no FIXUP, no sign registers.
//
// Parameters
//   WIDTH        operand, quotient and remainder width (>=2)
//
// Ports
//   Clk          in   1      system clock, rising edge
//   Reset        in   1      asynchronous active-low reset
//   LoadDivisor  in   1      active-low: load S into divisor register (IDLE only)
//   Run          in   1      active-low: start division of S by divisor (IDLE only)
//   S            in   WIDTH  switch input: divisor or dividend
//   Qval         out  WIDTH  quotient register
//   Rval         out  WIDTH  remainder register
//   Dval         out  WIDTH  divisor register
//   Busy         out  1      high in START, SHIFT, SUB and FIXUP
//   Done         out  1      high in DONE
//   DivByZero    out  1      set at START when divisor==0, cleared at next START
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadDivisor,
    input  logic             Run,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic [WIDTH-1:0] Dval,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    import div_pkg::*;

    localparam int DIV_CNT_W = div_cnt_w(WIDTH);

    div_state_t           state, state_n;
    logic [WIDTH-1:0]     q_reg, q_n;
    logic [WIDTH-1:0]     r_reg, r_n;
    logic [WIDTH-1:0]     d_reg, d_n;
    logic [DIV_CNT_W-1:0] cnt, cnt_n;
    logic                 dbz, dbz_n;

    // Operand magnitudes seen by the datapath.
    logic [WIDTH-1:0]     d_mag;
    logic [WIDTH-1:0]     s_mag;

    logic [WIDTH-1:0]     r_sh, q_sh, r_new;
    logic                 q_bit;

`ifdef SIGNED_DIV_EN
    logic                 neg_q, neg_q_n;
    logic                 neg_r, neg_r_n;

    // Dval keeps the value as loaded; only the datapath sees the magnitude.
    // -2^(W-1) maps to 2^(W-1), which is still correct read as unsigned.
    assign d_mag = d_reg[WIDTH-1] ? -d_reg : d_reg;
    assign s_mag = S[WIDTH-1]     ? -S     : S;
`else
    assign d_mag = d_reg;
    assign s_mag = S;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r     (r_reg),
        .q     (q_reg),
        .d     (d_mag),
        .r_sh  (r_sh),
        .q_sh  (q_sh),
        .r_new (r_new),
        .q_bit (q_bit)
    );

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                // Run has priority over LoadDivisor.
                if (!Run)              state_n = ST_START;
                else if (!LoadDivisor) state_n = ST_LOAD_D;
            end
            ST_LOAD_D: state_n = ST_IDLE;
            ST_START: begin
                if (d_reg == '0) state_n = ST_DONE;
                else             state_n = ST_SHIFT;
            end
            ST_SHIFT: state_n = ST_SUB;
            ST_SUB: begin
                if (cnt == DIV_CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                    state_n = ST_FIXUP;
`else
                    state_n = ST_DONE;
`endif
                end else begin
                    state_n = ST_SHIFT;
                end
            end
`ifdef SIGNED_DIV_EN
            ST_FIXUP: state_n = ST_DONE;
`endif
            ST_DONE: begin
                // Holding Run low keeps the result; no automatic restart.
                if (Run) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next datapath values
    // -----------------------------------------------------------------------
    always_comb begin
        q_n   = q_reg;
        r_n   = r_reg;
        d_n   = d_reg;
        cnt_n = cnt;
        dbz_n = dbz;
`ifdef SIGNED_DIV_EN
        neg_q_n = neg_q;
        neg_r_n = neg_r;
`endif
        case (state)
            ST_LOAD_D: d_n = S;
            ST_START: begin
                cnt_n = '0;
                dbz_n = (d_reg == '0);
                if (d_reg == '0) begin
                    // Divide-by-zero result: all-ones quotient, raw dividend.
                    q_n = '1;
                    r_n = S;
                end else begin
                    q_n = s_mag;
                    r_n = '0;
                end
`ifdef SIGNED_DIV_EN
                neg_q_n = S[WIDTH-1] ^ d_reg[WIDTH-1];
                neg_r_n = S[WIDTH-1];
`endif
            end
            ST_SHIFT: begin
                r_n = r_sh;
                q_n = q_sh;
            end
            ST_SUB: begin
                r_n   = r_new;
                q_n   = {q_reg[WIDTH-1:1], q_bit};
                cnt_n = cnt + 1'b1;
            end
`ifdef SIGNED_DIV_EN
            ST_FIXUP: begin
                if (neg_q) q_n = -q_reg;
                if (neg_r) r_n = -r_reg;
            end
`endif
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            q_reg <= '0;
            r_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            q_reg <= q_n;
            r_reg <= r_n;
            d_reg <= d_n;
            cnt   <= cnt_n;
            dbz   <= dbz_n;
`ifdef SIGNED_DIV_EN
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
`endif
        end
    end

    assign Qval      = q_reg;
    assign Rval      = r_reg;
    assign Dval      = d_reg;
    assign DivByZero = dbz;
    assign Done      = (state == ST_DONE);
    assign Busy      = (state == ST_START) || (state == ST_SHIFT) ||
                       (state == ST_SUB)   || (state == ST_FIXUP);

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=8). Expected quotient and
//   remainder come from plain integer division; the signed build is selected
//   with SIGNED_DIV_EN, as for the design.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W     = 8;
`ifdef SIGNED_DIV_EN
    localparam int LAT   = 2*W + 2;
`else
    localparam int LAT   = 2*W + 1;
`endif
    localparam int LIMIT = 100;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         LoadDivisor = 1'b1;
    logic         Run = 1'b1;
    logic [W-1:0] S = '0;
    logic [W-1:0] Qval, Rval, Dval;
    logic         Busy, Done, DivByZero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .LoadDivisor (LoadDivisor),
        .Run         (Run),
        .S           (S),
        .Qval        (Qval),
        .Rval        (Rval),
        .Dval        (Dval),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division (truncating toward zero in the signed build).
    function automatic void ref_div(input logic [W-1:0] s, input logic [W-1:0] d,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (d == '0) begin
            q = '1;
            r = s;
        end else begin
`ifdef SIGNED_DIV_EN
            int sv;
            int dv;
            sv = $signed(s);
            dv = $signed(d);
            q  = W'(sv / dv);
            r  = W'(sv % dv);
`else
            q  = s / d;
            r  = s % d;
`endif
        end
    endfunction

    task automatic load_div(input logic [W-1:0] d);
        @(negedge Clk);
        S = d;
        LoadDivisor = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        LoadDivisor = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Leaves Run low; returns at the falling edge after the sampling edge.
    task automatic start_run(input logic [W-1:0] s);
        @(negedge Clk);
        S = s;
        Run = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Counts rising edges after the sampling edge until Done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < LIMIT) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
    endtask

    task automatic do_div(input logic [W-1:0] d, input logic [W-1:0] s,
                          input string tag);
        logic [W-1:0] eq, er;
        int lat;
        ref_div(s, d, eq, er);
        load_div(d);
        check_val({tag, "_dval"}, Dval, d);
        start_run(s);
        Run = 1'b1;
        check_val({tag, "_busy"}, Busy, 1);
        wait_done(lat);
        check_val({tag, "_q"}, Qval, eq);
        check_val({tag, "_r"}, Rval, er);
        check_val({tag, "_dbz"}, DivByZero, (d == '0));
        if (d == '0)
            check_val({tag, "_lat_dbz_ok"}, (lat >= 1 && lat <= 2), 1);
        else
            check_val({tag, "_lat"}, lat, LAT);
        @(posedge Clk);
        @(negedge Clk);
        check_val({tag, "_idle_done"}, Done, 0);
    endtask

    initial begin
        logic [W-1:0] d, s, eq, er;
        logic seen_done, busy_after_done;

        // Reset state
        #12;
        check_val("rst_q", Qval, 0);
        check_val("rst_r", Rval, 0);
        check_val("rst_d", Dval, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_done", Done, 0);
        check_val("rst_dbz", DivByZero, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Directed cases, including the divisor extremes and divide-by-zero.
        do_div(8'h07, 8'hC8, "d07_sC8");
`ifndef SIGNED_DIV_EN
        check_val("c200_7_q", Qval, 8'h1C);
        check_val("c200_7_r", Rval, 8'h04);
`endif
        do_div(8'h01, 8'hFF, "d01_sFF");
`ifndef SIGNED_DIV_EN
        check_val("c255_1_q", Qval, 8'hFF);
        check_val("c255_1_r", Rval, 8'h00);
`endif
        do_div(8'hFF, 8'h01, "dFF_s01");
`ifndef SIGNED_DIV_EN
        check_val("c1_255_q", Qval, 8'h00);
        check_val("c1_255_r", Rval, 8'h01);
`endif
        do_div(8'h00, 8'h2A, "d00_s2A");
        check_val("c_dz_q", Qval, 8'hFF);
        check_val("c_dz_r", Rval, 8'h2A);
        check_val("c_dz_flag", DivByZero, 1);
        do_div(8'h03, 8'h64, "d03_s64");
        check_val("c_dz_clear", DivByZero, 0);
`ifdef SIGNED_DIV_EN
        do_div(8'h02, 8'hF9, "s_d02_sF9");
        check_val("c_m7_2_q", Qval, 8'hFD);
        check_val("c_m7_2_r", Rval, 8'hFF);
        do_div(8'hFF, 8'h80, "s_dFF_s80");
        check_val("c_min_m1_q", Qval, 8'h80);
        check_val("c_min_m1_r", Rval, 8'h00);
`endif

        // Reset asserted mid-division (count==3 after 7 edges).
        load_div(8'h05);
        start_run(8'hAB);
        Run = 1'b1;
        repeat (7) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_val("midrst_q", Qval, 0);
        check_val("midrst_r", Rval, 0);
        check_val("midrst_d", Dval, 0);
        check_val("midrst_busy", Busy, 0);
        check_val("midrst_done", Done, 0);
        check_val("midrst_dbz", DivByZero, 0);
        @(negedge Clk);
        Reset = 1'b1;
        do_div(8'h05, 8'hAB, "after_rst");

        // Run held low for 40 cycles; LoadDivisor pulsed while busy.
        load_div(8'h07);
        ref_div(8'h64, 8'h07, eq, er);
        start_run(8'h64);
        repeat (2) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        LoadDivisor = 1'b0;
        S = 8'h33;
        @(posedge Clk);
        @(negedge Clk);
        LoadDivisor = 1'b1;
        seen_done = 1'b0;
        busy_after_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (seen_done && (Busy || !Done)) busy_after_done = 1'b1;
            if (Done) seen_done = 1'b1;
        end
        check_val("hold_done", Done, 1);
        check_val("hold_single", busy_after_done, 0);
        check_val("hold_q", Qval, eq);
        check_val("hold_r", Rval, er);
        check_val("hold_dval", Dval, 8'h07);
        Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_val("release_done", Done, 0);
        check_val("release_busy", Busy, 0);

        // Randomized operands, biased toward small and zero divisors.
        for (int i = 0; i < 30; i++) begin
            s = W'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       d = '0;
                1, 2:    d = W'($urandom_range(1, 15));
                default: d = W'($urandom_range(0, 255));
            endcase
            do_div(d, s, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_divider
